// File: rtl/write_back_stage.sv
// -----------------------------------------------------------------------------
// write_back_stage
// MEM/WB pipeline register and write-back logic for the 5-stage MIPS core.
// The register captures the memory-stage results on each rising edge. The
// write-back value is then produced combinationally from the registered fields
// only, so there is no path from any input straight to an output.
//
// Ports
//   clock               core clock, rising-edge active
//   reset               asynchronous reset, active low
//   stall               hold the MEM/WB register contents
//   flush               load a bubble (has priority over stall)
//   memValid            memory-stage slot holds a real instruction
//   aluOutput           ALU result; also the data address for loads
//   memoryData          data-memory read word
//   linkAddress         PC+8 for jal/jalr
//   destRegister        destination register index
//   shouldWriteRegister instruction writes the register file
//   writeBackSelect     0 ALU, 1 memory, 2 link, 3 reserved (acts as ALU)
//   loadType            0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, others LW
//   wbValid             WB slot holds a real instruction
//   wbWriteEnable       register-file write enable ($0 writes suppressed)
//   wbDestRegister      register-file write index
//   wbWriteData         register-file write data / WB forwarding value
//   retiredCount        number of retired instructions (wraps silently)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module write_back_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  memValid,
    input  logic [DATA_W-1:0]     aluOutput,
    input  logic [DATA_W-1:0]     memoryData,
    input  logic [DATA_W-1:0]     linkAddress,
    input  logic [REG_ADDR_W-1:0] destRegister,
    input  logic                  shouldWriteRegister,
    input  logic [1:0]            writeBackSelect,
    input  logic [2:0]            loadType,
    output logic                  wbValid,
    output logic                  wbWriteEnable,
    output logic [REG_ADDR_W-1:0] wbDestRegister,
    output logic [DATA_W-1:0]     wbWriteData,
    output logic [31:0]           retiredCount
);

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_LINK = 2'd2,
        WB_RSVD = 2'd3
    } wb_sel_e;

    typedef enum logic [2:0] {
        LD_LW  = 3'd0,
        LD_LH  = 3'd1,
        LD_LHU = 3'd2,
        LD_LB  = 3'd3,
        LD_LBU = 3'd4
    } load_type_e;

    // Extract a load value from a little-endian word. Halfwords use only
    // addr[1] (addr[0] is ignored, so no alignment trap); LW ignores the offset.
    function automatic logic [DATA_W-1:0] extract_load(
        input logic [2:0]        lt,
        input logic [1:0]        offset,
        input logic [DATA_W-1:0] word
    );
        logic [7:0]        byte_v;
        logic [15:0]       half_v;
        logic [DATA_W-1:0] result_v;
        case (offset)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            2'd3:    byte_v = word[31:24];
            default: byte_v = word[7:0];
        endcase
        half_v = offset[1] ? word[31:16] : word[15:0];
        case (lt)
            LD_LH:   result_v = {{16{half_v[15]}}, half_v};
            LD_LHU:  result_v = {16'h0000, half_v};
            LD_LB:   result_v = {{24{byte_v[7]}}, byte_v};
            LD_LBU:  result_v = {24'h000000, byte_v};
            default: result_v = word;
        endcase
        return result_v;
    endfunction

    // MEM/WB register fields
    logic                  valid_q,  valid_d;
    logic                  wr_q,     wr_d;
    logic [REG_ADDR_W-1:0] dest_q,   dest_d;
    logic [1:0]            sel_q,    sel_d;
    logic [2:0]            load_q,   load_d;
    logic [DATA_W-1:0]     alu_q,    alu_d;
    logic [DATA_W-1:0]     mem_q,    mem_d;
    logic [DATA_W-1:0]     link_q,   link_d;
    logic [31:0]           count_q,  count_d;
    logic                  retire_s;
    logic [DATA_W-1:0]     load_val_s;

    // Next-state for the MEM/WB fields: flush beats stall beats capture
    always_comb begin
        valid_d = valid_q;
        wr_d    = wr_q;
        dest_d  = dest_q;
        sel_d   = sel_q;
        load_d  = load_q;
        alu_d   = alu_q;
        mem_d   = mem_q;
        link_d  = link_q;
        if (flush) begin
            valid_d = 1'b0;
            wr_d    = 1'b0;
            dest_d  = {REG_ADDR_W{1'b0}};
            sel_d   = 2'd0;
            load_d  = 3'd0;
            alu_d   = {DATA_W{1'b0}};
            mem_d   = {DATA_W{1'b0}};
            link_d  = {DATA_W{1'b0}};
        end else if (!stall) begin
            valid_d = memValid;
            wr_d    = shouldWriteRegister;
            dest_d  = destRegister;
            sel_d   = writeBackSelect;
            load_d  = loadType;
            alu_d   = aluOutput;
            mem_d   = memoryData;
            link_d  = linkAddress;
        end else begin
            valid_d = valid_q;
        end
    end

    // A valid slot retires on the edge it leaves WB, so a stalled slot
    // counts once, when it finally moves on (or is flushed).
    always_comb begin
        retire_s = valid_q & (~stall | flush);
        if (retire_s) begin
            count_d = count_q + 32'd1;
        end else begin
            count_d = count_q;
        end
    end

    // MEM/WB register and retired counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            wr_q    <= 1'b0;
            dest_q  <= {REG_ADDR_W{1'b0}};
            sel_q   <= 2'd0;
            load_q  <= 3'd0;
            alu_q   <= {DATA_W{1'b0}};
            mem_q   <= {DATA_W{1'b0}};
            link_q  <= {DATA_W{1'b0}};
            count_q <= 32'd0;
        end else begin
            valid_q <= valid_d;
            wr_q    <= wr_d;
            dest_q  <= dest_d;
            sel_q   <= sel_d;
            load_q  <= load_d;
            alu_q   <= alu_d;
            mem_q   <= mem_d;
            link_q  <= link_d;
            count_q <= count_d;
        end
    end

    // Write-back source mux; reserved encoding behaves as ALU
    always_comb begin
        load_val_s = extract_load(load_q, alu_q[1:0], mem_q);
        case (sel_q)
            WB_ALU:  wbWriteData = alu_q;
            WB_MEM:  wbWriteData = load_val_s;
            WB_LINK: wbWriteData = link_q;
            WB_RSVD: wbWriteData = alu_q;
            default: wbWriteData = alu_q;
        endcase
    end

    assign wbValid        = valid_q;
    assign wbWriteEnable  = valid_q & wr_q & (dest_q != {REG_ADDR_W{1'b0}});
    assign wbDestRegister = dest_q;
    assign retiredCount   = count_q;

endmodule

// File: tb/tb_write_back_stage.sv
`timescale 1ns/1ps
module tb_write_back_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        memValid = 1'b0;
    logic [31:0] aluOutput = 32'd0;
    logic [31:0] memoryData = 32'd0;
    logic [31:0] linkAddress = 32'd0;
    logic [4:0]  destRegister = 5'd0;
    logic        shouldWriteRegister = 1'b0;
    logic [1:0]  writeBackSelect = 2'd0;
    logic [2:0]  loadType = 3'd0;
    logic        wbValid;
    logic        wbWriteEnable;
    logic [4:0]  wbDestRegister;
    logic [31:0] wbWriteData;
    logic [31:0] retiredCount;

    write_back_stage dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .memValid(memValid), .aluOutput(aluOutput), .memoryData(memoryData),
        .linkAddress(linkAddress), .destRegister(destRegister),
        .shouldWriteRegister(shouldWriteRegister),
        .writeBackSelect(writeBackSelect), .loadType(loadType),
        .wbValid(wbValid), .wbWriteEnable(wbWriteEnable),
        .wbDestRegister(wbDestRegister), .wbWriteData(wbWriteData),
        .retiredCount(retiredCount)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        v;
        logic        we;
        logic [4:0]  d;
        logic [31:0] data;
        logic [31:0] cnt;
    } exp_t;

    exp_t   exp_q[$];
    int     n_vec = 0;
    int     n_bad = 0;
    string  cur_tag = "reset";

    // Model state of the WB slot as seen after the most recent edge
    logic        m_v = 1'b0;
    logic        m_we = 1'b0;
    logic [4:0]  m_d = 5'd0;
    logic [31:0] m_data = 32'd0;
    logic [31:0] m_cnt = 32'd0;

    // Monitor: one expected entry per clock edge, checked on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (wbValid !== e.v || wbWriteEnable !== e.we || wbDestRegister !== e.d ||
                    wbWriteData !== e.data || retiredCount !== e.cnt) begin
                    n_bad++;
                    $display("FAIL %s: got v=%b we=%b d=%0d data=%h cnt=%h, want v=%b we=%b d=%0d data=%h cnt=%h",
                             cur_tag, wbValid, wbWriteEnable, wbDestRegister, wbWriteData, retiredCount,
                             e.v, e.we, e.d, e.data, e.cnt);
                end
            end
        end
    end

    // Immediate check that every output reads as after reset
    task automatic check_zero(input string tag);
        n_vec++;
        if (wbValid !== 1'b0 || wbWriteEnable !== 1'b0 || wbDestRegister !== 5'd0 ||
            wbWriteData !== 32'd0 || retiredCount !== 32'd0) begin
            n_bad++;
            $display("FAIL %s: got v=%b we=%b d=%0d data=%h cnt=%h, want all zero",
                     tag, wbValid, wbWriteEnable, wbDestRegister, wbWriteData, retiredCount);
        end
    endtask

    // One clock of stimulus; exp_data is the hand-computed write-back value
    task automatic cycle(input string tag, input logic v, input logic wr, input logic [4:0] dst,
                         input logic [1:0] sel, input logic [2:0] lt, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [31:0] link,
                         input logic st, input logic fl, input logic [31:0] exp_data);
        exp_t e;
        memValid = v; shouldWriteRegister = wr; destRegister = dst; writeBackSelect = sel;
        loadType = lt; aluOutput = alu; memoryData = mem; linkAddress = link;
        stall = st; flush = fl;
        if (m_v && (!st || fl)) m_cnt = m_cnt + 32'd1;
        if (fl) begin
            m_v = 1'b0; m_we = 1'b0; m_d = 5'd0; m_data = 32'd0;
        end else if (!st) begin
            m_v = v; m_we = v && wr && (dst != 5'd0); m_d = dst; m_data = exp_data;
        end
        e = '{v: m_v, we: m_we, d: m_d, data: m_data, cnt: m_cnt};
        @(posedge clock);
        cur_tag = tag;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic idle(input string tag);
        cycle(tag, 1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    localparam logic [31:0] WORD = 32'h80FF7F01;

    initial begin
        // Reset held for three edges, outputs zero throughout
        repeat (3) begin
            @(posedge clock); #1;
            check_zero("in_reset");
        end
        reset = 1'b1;
        for (int i = 0; i < 5; i++) idle("idle_after_reset");

        // ALU write-back, then the retire shows up one cycle later
        cycle("alu_wb", 1'b1, 1'b1, 5'd8, 2'd0, 3'd0, 32'h12345678, 32'd0, 32'd0, 1'b0, 1'b0, 32'h12345678);
        idle("alu_retire");

        // Loads out of 0x80FF7F01
        cycle("lb_off0",  1'b1, 1'b1, 5'd9, 2'd1, 3'd3, 32'h00001000, WORD, 32'd0, 1'b0, 1'b0, 32'h00000001);
        cycle("lb_off3",  1'b1, 1'b1, 5'd9, 2'd1, 3'd3, 32'h00001003, WORD, 32'd0, 1'b0, 1'b0, 32'hFFFFFF80);
        cycle("lbu_off2", 1'b1, 1'b1, 5'd9, 2'd1, 3'd4, 32'h00001002, WORD, 32'd0, 1'b0, 1'b0, 32'h000000FF);
        cycle("lh_off2",  1'b1, 1'b1, 5'd9, 2'd1, 3'd1, 32'h00001002, WORD, 32'd0, 1'b0, 1'b0, 32'hFFFF80FF);
        cycle("lhu_off2", 1'b1, 1'b1, 5'd9, 2'd1, 3'd2, 32'h00001002, WORD, 32'd0, 1'b0, 1'b0, 32'h000080FF);
        cycle("lhu_off3", 1'b1, 1'b1, 5'd9, 2'd1, 3'd2, 32'h00001003, WORD, 32'd0, 1'b0, 1'b0, 32'h000080FF);
        cycle("lh_off0",  1'b1, 1'b1, 5'd9, 2'd1, 3'd1, 32'h00001000, WORD, 32'd0, 1'b0, 1'b0, 32'h00007F01);
        cycle("lw",       1'b1, 1'b1, 5'd9, 2'd1, 3'd0, 32'h00001002, WORD, 32'd0, 1'b0, 1'b0, 32'h80FF7F01);
        cycle("lt_other", 1'b1, 1'b1, 5'd9, 2'd1, 3'd7, 32'h00001001, WORD, 32'd0, 1'b0, 1'b0, 32'h80FF7F01);

        // $0 suppression, link, reserved select, bubble with write set
        cycle("dest_zero", 1'b1, 1'b1, 5'd0, 2'd0, 3'd0, 32'h0000DEAD, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0000DEAD);
        cycle("jal_link",  1'b1, 1'b1, 5'd31, 2'd2, 3'd0, 32'h11111111, 32'd0, 32'h00400010, 1'b0, 1'b0, 32'h00400010);
        cycle("sel_rsvd",  1'b1, 1'b1, 5'd3, 2'd3, 3'd0, 32'hCAFEF00D, 32'h22222222, 32'h33333333, 1'b0, 1'b0, 32'hCAFEF00D);
        cycle("bubble_wr", 1'b0, 1'b1, 5'd4, 2'd0, 3'd0, 32'h00000044, 32'd0, 32'd0, 1'b0, 1'b0, 32'h00000044);
        idle("bubble_no_count");

        // Stall holds a valid load slot (including its memory word) for three cycles
        cycle("stall_load", 1'b1, 1'b1, 5'd5, 2'd1, 3'd3, 32'h00002003, WORD, 32'd0, 1'b0, 1'b0, 32'hFFFFFF80);
        cycle("stall_1", 1'b1, 1'b1, 5'd6, 2'd0, 3'd0, 32'h0BADBAD1, 32'h0, 32'd0, 1'b1, 1'b0, 32'h0BADBAD1);
        cycle("stall_2", 1'b1, 1'b1, 5'd7, 2'd0, 3'd0, 32'h0BADBAD2, 32'h1, 32'd0, 1'b1, 1'b0, 32'h0BADBAD2);
        cycle("stall_3", 1'b1, 1'b1, 5'd8, 2'd2, 3'd0, 32'h0BADBAD3, 32'h2, 32'h5, 1'b1, 1'b0, 32'h00000005);
        cycle("stall_release", 1'b1, 1'b1, 5'd10, 2'd0, 3'd0, 32'hAAAA0001, 32'd0, 32'd0, 1'b0, 1'b0, 32'hAAAA0001);
        cycle("stall_flush", 1'b1, 1'b1, 5'd11, 2'd0, 3'd0, 32'hBBBB0002, 32'd0, 32'd0, 1'b1, 1'b1, 32'hBBBB0002);
        idle("after_flush");

        // Async reset between edges while a write is in WB
        cycle("pre_reset", 1'b1, 1'b1, 5'd12, 2'd0, 3'd0, 32'h0C0C0C0C, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0C0C0C0C);
        #6;
        reset = 1'b0;
        #1;
        check_zero("async_reset");
        m_v = 1'b0; m_we = 1'b0; m_d = 5'd0; m_data = 32'd0; m_cnt = 32'd0;
        @(posedge clock); #1;
        check_zero("reset_held");
        reset = 1'b1;

        // Counter wrap: preload all-ones, then retire one instruction
        force dut.count_q = 32'hFFFFFFFF;
        #1;
        release dut.count_q;
        m_cnt = 32'hFFFFFFFF;
        cycle("wrap_load", 1'b1, 1'b1, 5'd13, 2'd0, 3'd0, 32'h00000077, 32'd0, 32'd0, 1'b0, 1'b0, 32'h00000077);
        idle("wrap_retire");
        idle("wrap_idle");

        @(negedge clock); #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

endmodule
